// File: rtl/calc2_pkg.sv
// rtl/calc2_pkg.sv - shared calc2 codes, widths and port issuer state
package calc2_pkg;

  localparam int CMD_W     = 4;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 2;
  localparam int RESP_W    = 2;
  localparam int NUM_PORTS = 4;
  localparam int NUM_TAGS  = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } calcCmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_INV  = 2'd3
  } calcResp_e;

  typedef enum logic [1:0] {
    PORT_IDLE = 2'd0,
    PORT_CMD  = 2'd1,
    PORT_DATA = 2'd2
  } portState_e;

  // Lowest-numbered clear bit; callers only use it when at least one tag is free.
  function automatic logic [TAG_W-1:0] lowestFree(input logic [NUM_TAGS-1:0] busy);
    logic [TAG_W-1:0] idx;
    idx = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!busy[t]) idx = TAG_W'(t);
    end
    return idx;
  endfunction

endpackage

// File: rtl/calc2_port_issuer.sv
// rtl/calc2_port_issuer.sv - one calc2 port: two-beat command issue and tag bookkeeping
module calc2_port_issuer
  import calc2_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              accept,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [RESP_W-1:0] resp,
  input  logic [TAG_W-1:0]  respTag,
  output logic [CMD_W-1:0]  reqCmd,
  output logic [DATA_W-1:0] reqData,
  output logic [TAG_W-1:0]  reqTag,
  output logic [NUM_TAGS-1:0] tagBusy,
  output logic              protoErr,
  output logic              ready
);

  portState_e          state, stateNext;
  logic [DATA_W-1:0]   op2Hold;
  logic [CMD_W-1:0]    cmdNext;
  logic [DATA_W-1:0]   dataNext;
  logic [TAG_W-1:0]    tagNext;
  logic [TAG_W-1:0]    allocTag;
  logic [NUM_TAGS-1:0] freeMask;
  logic [NUM_TAGS-1:0] allocMask;
  logic [NUM_TAGS-1:0] busyNext;
  logic                acceptTaken;
  logic                respHit;
  logic                errNext;

  assign ready = (state != PORT_CMD) && !(&tagBusy);

  always_comb begin
    stateNext   = state;
    cmdNext     = '0;
    dataNext    = '0;
    tagNext     = '0;
    acceptTaken = 1'b0;
    allocTag    = lowestFree(tagBusy);
    unique case (state)
      PORT_CMD: begin
        stateNext = PORT_DATA;
        dataNext  = op2Hold;
      end
      default: begin
        if (accept && !(&tagBusy)) begin
          acceptTaken = 1'b1;
          stateNext   = PORT_CMD;
          cmdNext     = cmd;
          dataNext    = op1;
          tagNext     = allocTag;
        end else begin
          stateNext = PORT_IDLE;
        end
      end
    endcase
  end

  // Allocation looks only at the current busy map, so a tag freed this cycle waits one cycle.
  always_comb begin
    respHit   = (resp != RESP_NONE);
    freeMask  = '0;
    allocMask = '0;
    errNext   = protoErr;
    if (respHit) begin
      if (tagBusy[respTag]) freeMask = NUM_TAGS'(1) << respTag;
      else                  errNext  = 1'b1;
    end
    if (acceptTaken) allocMask = NUM_TAGS'(1) << allocTag;
    busyNext = (tagBusy & ~freeMask) | allocMask;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= PORT_IDLE;
      op2Hold  <= '0;
      reqCmd   <= '0;
      reqData  <= '0;
      reqTag   <= '0;
      tagBusy  <= '0;
      protoErr <= 1'b0;
    end else begin
      state    <= stateNext;
      reqCmd   <= cmdNext;
      reqData  <= dataNext;
      reqTag   <= tagNext;
      tagBusy  <= busyNext;
      protoErr <= errNext;
      if (acceptTaken) op2Hold <= op2;
    end
  end

endmodule

// File: rtl/calc2_req_dispatch.sv
// rtl/calc2_req_dispatch.sv - steers requests to four independent calc2 port issuers
module calc2_req_dispatch
  import calc2_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_port,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  output logic [CMD_W-1:0]  req1_cmd_in,
  output logic [DATA_W-1:0] req1_data_in,
  output logic [TAG_W-1:0]  req1_tag_in,
  output logic [CMD_W-1:0]  req2_cmd_in,
  output logic [DATA_W-1:0] req2_data_in,
  output logic [TAG_W-1:0]  req2_tag_in,
  output logic [CMD_W-1:0]  req3_cmd_in,
  output logic [DATA_W-1:0] req3_data_in,
  output logic [TAG_W-1:0]  req3_tag_in,
  output logic [CMD_W-1:0]  req4_cmd_in,
  output logic [DATA_W-1:0] req4_data_in,
  output logic [TAG_W-1:0]  req4_tag_in,
  input  logic [RESP_W-1:0] out_resp1,
  input  logic [TAG_W-1:0]  out_tag1,
  input  logic [RESP_W-1:0] out_resp2,
  input  logic [TAG_W-1:0]  out_tag2,
  input  logic [RESP_W-1:0] out_resp3,
  input  logic [TAG_W-1:0]  out_tag3,
  input  logic [RESP_W-1:0] out_resp4,
  input  logic [TAG_W-1:0]  out_tag4,
  output logic [NUM_PORTS*NUM_TAGS-1:0] tag_busy,
  output logic              proto_err
);

  logic [RESP_W-1:0] respArr [NUM_PORTS];
  logic [TAG_W-1:0]  respTagArr [NUM_PORTS];
  logic [CMD_W-1:0]  cmdArr  [NUM_PORTS];
  logic [DATA_W-1:0] dataArr [NUM_PORTS];
  logic [TAG_W-1:0]  tagArr  [NUM_PORTS];
  logic [NUM_PORTS-1:0][NUM_TAGS-1:0] busyArr;
  logic [NUM_PORTS-1:0] readyVec;
  logic [NUM_PORTS-1:0] errVec;
  logic [NUM_PORTS-1:0] acceptVec;

  assign respArr[0] = out_resp1;  assign respTagArr[0] = out_tag1;
  assign respArr[1] = out_resp2;  assign respTagArr[1] = out_tag2;
  assign respArr[2] = out_resp3;  assign respTagArr[2] = out_tag3;
  assign respArr[3] = out_resp4;  assign respTagArr[3] = out_tag4;

  assign in_ready = readyVec[in_port];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
    assign acceptVec[p] = in_valid && in_ready && (in_port == 2'(p));

    calc2_port_issuer uIssuer (
      .clk      (c_clk),
      .rstN     (reset_n),
      .accept   (acceptVec[p]),
      .cmd      (in_cmd),
      .op1      (in_op1),
      .op2      (in_op2),
      .resp     (respArr[p]),
      .respTag  (respTagArr[p]),
      .reqCmd   (cmdArr[p]),
      .reqData  (dataArr[p]),
      .reqTag   (tagArr[p]),
      .tagBusy  (busyArr[p]),
      .protoErr (errVec[p]),
      .ready    (readyVec[p])
    );
  end

  assign req1_cmd_in = cmdArr[0];  assign req1_data_in = dataArr[0];  assign req1_tag_in = tagArr[0];
  assign req2_cmd_in = cmdArr[1];  assign req2_data_in = dataArr[1];  assign req2_tag_in = tagArr[1];
  assign req3_cmd_in = cmdArr[2];  assign req3_data_in = dataArr[2];  assign req3_tag_in = tagArr[2];
  assign req4_cmd_in = cmdArr[3];  assign req4_data_in = dataArr[3];  assign req4_tag_in = tagArr[3];

  assign tag_busy  = busyArr;
  assign proto_err = |errVec;

endmodule

// File: tb/tb_calc2_req_dispatch.sv
// tb/tb_calc2_req_dispatch.sv - directed and randomized checks of calc2_req_dispatch
module tb_calc2_req_dispatch;

  logic c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  logic        reset_n;
  logic        in_valid;
  wire         in_ready;
  logic [1:0]  in_port;
  logic [3:0]  in_cmd;
  logic [31:0] in_op1, in_op2;
  wire  [3:0]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  wire  [31:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  wire  [1:0]  req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in;
  wire  [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
  wire  [1:0]  out_tag1, out_tag2, out_tag3, out_tag4;
  wire  [15:0] tag_busy;
  wire         proto_err;

  logic [1:0] dResp [4];
  logic [1:0] dTag  [4];
  wire  [3:0]  rCmd  [4];
  wire  [31:0] rData [4];
  wire  [1:0]  rTag  [4];

  assign out_resp1 = dResp[0];  assign out_tag1 = dTag[0];
  assign out_resp2 = dResp[1];  assign out_tag2 = dTag[1];
  assign out_resp3 = dResp[2];  assign out_tag3 = dTag[2];
  assign out_resp4 = dResp[3];  assign out_tag4 = dTag[3];
  assign rCmd[0] = req1_cmd_in;  assign rData[0] = req1_data_in;  assign rTag[0] = req1_tag_in;
  assign rCmd[1] = req2_cmd_in;  assign rData[1] = req2_data_in;  assign rTag[1] = req2_tag_in;
  assign rCmd[2] = req3_cmd_in;  assign rData[2] = req3_data_in;  assign rTag[2] = req3_tag_in;
  assign rCmd[3] = req4_cmd_in;  assign rData[3] = req4_data_in;  assign rTag[3] = req4_tag_in;

  calc2_req_dispatch dut (
    .c_clk(c_clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_port(in_port),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .req1_cmd_in(req1_cmd_in), .req1_data_in(req1_data_in), .req1_tag_in(req1_tag_in),
    .req2_cmd_in(req2_cmd_in), .req2_data_in(req2_data_in), .req2_tag_in(req2_tag_in),
    .req3_cmd_in(req3_cmd_in), .req3_data_in(req3_data_in), .req3_tag_in(req3_tag_in),
    .req4_cmd_in(req4_cmd_in), .req4_data_in(req4_data_in), .req4_tag_in(req4_tag_in),
    .out_resp1(out_resp1), .out_tag1(out_tag1), .out_resp2(out_resp2), .out_tag2(out_tag2),
    .out_resp3(out_resp3), .out_tag3(out_tag3), .out_resp4(out_resp4), .out_tag4(out_tag4),
    .tag_busy(tag_busy), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per port, the beats still to appear on the request bus, plus tag sets.
  logic [3:0]  mBusy [4];
  logic        mErr;
  int          mPend [4];
  logic [37:0] mNext [4];
  logic [37:0] mAfter [4];

  task automatic tick;
    @(posedge c_clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0;
    in_port  = 2'd0;
    in_cmd   = 4'd0;
    in_op1   = 32'd0;
    in_op2   = 32'd0;
    for (int p = 0; p < 4; p++) begin
      dResp[p] = 2'd0;
      dTag[p]  = 2'd0;
    end
  endtask

  task automatic model_reset;
    mErr = 1'b0;
    for (int p = 0; p < 4; p++) begin
      mBusy[p] = 4'h0;
      mPend[p] = 0;
      mNext[p] = '0;
      mAfter[p] = '0;
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rCmd[p] !== 4'd0 || rData[p] !== 32'd0 || rTag[p] !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs port%0d got cmd %h data %h tag %h want all 0", p + 1, rCmd[p], rData[p], rTag[p]);
      end
    end
    checks++;
    if (tag_busy !== 16'h0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got tag_busy %h proto_err %b want 0000/0", tag_busy, proto_err);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_single_add;
    in_valid = 1'b1; in_port = 2'd0; in_cmd = 4'd1; in_op1 = 32'd5; in_op2 = 32'd7;
    tick();
    idle_inputs();
    checks++;
    if (rCmd[0] !== 4'd1 || rData[0] !== 32'd5 || rTag[0] !== 2'd0 || tag_busy !== 16'h0001) begin
      errors++;
      $display("FAIL add_cmd_beat got cmd %h data %h tag %h busy %h want 1/5/0/0001", rCmd[0], rData[0], rTag[0], tag_busy);
    end
    tick();
    checks++;
    if (rCmd[0] !== 4'd0 || rData[0] !== 32'd7 || rTag[0] !== 2'd0) begin
      errors++;
      $display("FAIL add_data_beat got cmd %h data %h tag %h want 0/7/0", rCmd[0], rData[0], rTag[0]);
    end
    tick();
    checks++;
    if (rCmd[0] !== 4'd0 || rData[0] !== 32'd0 || rTag[0] !== 2'd0) begin
      errors++;
      $display("FAIL add_idle got cmd %h data %h tag %h want 0/0/0", rCmd[0], rData[0], rTag[0]);
    end
    dResp[0] = 2'd1; dTag[0] = 2'd0;
    tick();
    idle_inputs();
    checks++;
    if (tag_busy !== 16'h0) begin
      errors++;
      $display("FAIL add_free got tag_busy %h want 0000", tag_busy);
    end
  endtask

  task automatic test_tag_exhaust;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_port = 2'd1; in_cmd = 4'd2;
      in_op1 = 32'(i + 10); in_op2 = 32'(i + 20);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL exhaust_ready req%0d got %b want 1", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (rTag[1] !== 2'(i) || rCmd[1] !== 4'd2 || rData[1] !== 32'(i + 10)) begin
        errors++;
        $display("FAIL exhaust_tag req%0d got tag %0d cmd %h data %h want %0d/2/%h", i, rTag[1], rCmd[1], rData[1], i, i + 10);
      end
      tick();
    end
    checks++;
    if (tag_busy !== 16'h00F0) begin
      errors++;
      $display("FAIL exhaust_busy got %h want 00f0", tag_busy);
    end
    for (int p = 0; p < 4; p++) begin
      in_port = 2'(p);
      #1;
      checks++;
      if (in_ready !== (p != 1)) begin
        errors++;
        $display("FAIL exhaust_ready_port%0d got %b want %b", p + 1, in_ready, p != 1);
      end
    end
  endtask

  task automatic test_tag_recycle;
    dResp[1] = 2'd1; dTag[1] = 2'd2;
    in_valid = 1'b1; in_port = 2'd1; in_cmd = 4'd1; in_op1 = 32'h55; in_op2 = 32'h66;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL recycle_same_cycle got ready %b want 0", in_ready);
    end
    tick();
    dResp[1] = 2'd0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || tag_busy !== 16'h00B0) begin
      errors++;
      $display("FAIL recycle_freed got ready %b busy %h want 1/00b0", in_ready, tag_busy);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (rTag[1] !== 2'd2 || rCmd[1] !== 4'd1 || rData[1] !== 32'h55 || tag_busy !== 16'h00F0) begin
      errors++;
      $display("FAIL recycle_tag got tag %0d cmd %h data %h busy %h want 2/1/55/00f0", rTag[1], rCmd[1], rData[1], tag_busy);
    end
    tick();
    checks++;
    if (rData[1] !== 32'h66) begin
      errors++;
      $display("FAIL recycle_data got %h want 66", rData[1]);
    end
    for (int t = 0; t < 4; t++) begin
      dResp[1] = 2'd2; dTag[1] = 2'(t);
      tick();
    end
    idle_inputs();
    checks++;
    if (tag_busy !== 16'h0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL recycle_drain got busy %h err %b want 0000/0", tag_busy, proto_err);
    end
  endtask

  task automatic test_parallel;
    logic [3:0] cmdList [4];
    cmdList[0] = 4'd1; cmdList[1] = 4'd2; cmdList[2] = 4'd5; cmdList[3] = 4'hF;
    for (int s = 0; s < 6; s++) begin
      if (s < 4) begin
        in_valid = 1'b1; in_port = 2'(s); in_cmd = cmdList[s];
        in_op1 = 32'(100 + s); in_op2 = 32'(200 + s);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL parallel_ready step%0d got %b want 1", s, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      for (int p = 0; p < 4; p++) begin
        logic [3:0]  eCmd;
        logic [31:0] eData;
        eCmd = 4'd0; eData = 32'd0;
        if (s == p)     begin eCmd = cmdList[p]; eData = 32'(100 + p); end
        if (s == p + 1) eData = 32'(200 + p);
        checks++;
        if (rCmd[p] !== eCmd || rData[p] !== eData || rTag[p] !== 2'd0) begin
          errors++;
          $display("FAIL parallel step%0d port%0d got %h/%h/%0d want %h/%h/0", s, p + 1, rCmd[p], rData[p], rTag[p], eCmd, eData);
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      dResp[p] = 2'd1; dTag[p] = 2'd0;
    end
    tick();
    idle_inputs();
    checks++;
    if (tag_busy !== 16'h0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL parallel_drain got busy %h err %b want 0000/0", tag_busy, proto_err);
    end
  endtask

  task automatic test_spurious;
    dResp[2] = 2'd1; dTag[2] = 2'd3;
    tick();
    idle_inputs();
    checks++;
    if (proto_err !== 1'b1 || tag_busy !== 16'h0) begin
      errors++;
      $display("FAIL spurious got err %b busy %h want 1/0000", proto_err, tag_busy);
    end
    tick();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL spurious_sticky got %b want 1", proto_err);
    end
  endtask

  task automatic test_reset_midop;
    in_valid = 1'b1; in_port = 2'd0; in_cmd = 4'd1; in_op1 = 32'hAAAA; in_op2 = 32'hBBBB;
    tick();
    idle_inputs();
    checks++;
    if (rCmd[0] !== 4'd1 || rData[0] !== 32'hAAAA) begin
      errors++;
      $display("FAIL midop_cmd got %h/%h want 1/aaaa", rCmd[0], rData[0]);
    end
    reset_n = 1'b0;
    #2;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rCmd[p] !== 4'd0 || rData[p] !== 32'd0 || rTag[p] !== 2'd0) begin
        errors++;
        $display("FAIL midop_reset port%0d got %h/%h/%0d want 0/0/0", p + 1, rCmd[p], rData[p], rTag[p]);
      end
    end
    checks++;
    if (tag_busy !== 16'h0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_state got busy %h err %b want 0000/0", tag_busy, proto_err);
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rCmd[0] !== 4'd0 || rData[0] !== 32'd0 || tag_busy !== 16'h0) begin
        errors++;
        $display("FAIL midop_after cycle%0d got %h/%h busy %h want 0/0/0000", c, rCmd[0], rData[0], tag_busy);
      end
    end
  endtask

  task automatic test_random(input int cycles, input bit allowSpurious);
    for (int c = 0; c < cycles; c++) begin
      logic        mReady, acc;
      logic [1:0]  alloc;
      logic [15:0] eBusy;
      in_valid = ($urandom % 4) != 0;
      in_port  = 2'($urandom);
      in_cmd   = 4'($urandom);
      in_op1   = $urandom;
      in_op2   = $urandom;
      for (int p = 0; p < 4; p++) begin
        dResp[p] = 2'd0;
        dTag[p]  = 2'($urandom);
        if ($urandom % 3 == 0) begin
          if (mBusy[p] != 4'h0 && (allowSpurious == 1'b0 || $urandom % 4 != 0)) begin
            while (!mBusy[p][dTag[p]]) dTag[p] = 2'($urandom);
            dResp[p] = 2'($urandom_range(1, 3));
          end else if (allowSpurious) begin
            dResp[p] = 2'($urandom_range(1, 3));
          end
        end
      end
      #1;
      mReady = (mPend[in_port] != 1) && (mBusy[in_port] != 4'hF);
      checks++;
      if (in_ready !== mReady) begin
        errors++;
        $display("FAIL rand_ready cycle%0d port%0d got %b want %b", c, in_port + 1, in_ready, mReady);
      end
      acc = in_valid && mReady;
      alloc = 2'd0;
      for (int t = 3; t >= 0; t--) if (!mBusy[in_port][t]) alloc = 2'(t);
      for (int p = 0; p < 4; p++) begin
        logic [3:0] nb;
        nb = mBusy[p];
        if (dResp[p] != 2'd0) begin
          if (mBusy[p][dTag[p]]) nb[dTag[p]] = 1'b0;
          else                   mErr = 1'b1;
        end
        if (acc && in_port == 2'(p)) begin
          nb[alloc] = 1'b1;
          mNext[p]  = {in_cmd, in_op1, alloc};
          mAfter[p] = {4'd0, in_op2, 2'd0};
          mPend[p]  = 2;
        end
        mBusy[p] = nb;
      end
      tick();
      for (int p = 0; p < 4; p++) begin
        logic [37:0] exp;
        exp = (mPend[p] > 0) ? mNext[p] : 38'd0;
        if (mPend[p] > 0) begin
          mNext[p] = mAfter[p];
          mPend[p]--;
        end
        checks++;
        if ({rCmd[p], rData[p], rTag[p]} !== exp) begin
          errors++;
          $display("FAIL rand_beat cycle%0d port%0d got %h/%h/%0d want %h/%h/%0d", c, p + 1, rCmd[p], rData[p], rTag[p], exp[37:34], exp[33:2], exp[1:0]);
        end
      end
      eBusy = {mBusy[3], mBusy[2], mBusy[1], mBusy[0]};
      checks++;
      if (tag_busy !== eBusy || proto_err !== mErr) begin
        errors++;
        $display("FAIL rand_tags cycle%0d got busy %h err %b want %h/%b", c, tag_busy, proto_err, eBusy, mErr);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    test_reset();
    test_single_add();
    test_tag_exhaust();
    test_tag_recycle();
    test_parallel();
    test_spurious();
    test_reset_midop();
    model_reset();
    test_random(300, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    test_random(300, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc2_req_dispatch.md
CALC2_REQ_DISPATCH -- requirements
Module: calc2_req_dispatch

Interface
REQ-001 SHALL have ports:
- c_clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request available.
- in_ready  out  1  dispatcher can accept the presented request.
- in_port  in  2  target calc2 port (0..3 = port 1..4).
- in_cmd  in  4  calc2 command code.
- in_op1  in  32  first operand.
- in_op2  in  32  second operand.
- reqN_cmd_in  out  4  command to calc2 port N (N=1..4).
- reqN_data_in  out  32  operand to calc2 port N.
- reqN_tag_in  out  2  tag to calc2 port N.
- out_respN  in  2  calc2 response code, port N.
- out_tagN  in  2  calc2 response tag, port N.
- tag_busy  out  16  outstanding-tag map, bit 4*(N-1)+t.
- proto_err  out  1  sticky: response seen for a non-outstanding tag.

Function
REQ-002 SHALL run one per-port FSM (IDLE, CMD, DATA) for each of the 4 ports.
REQ-003 SHALL drive in_ready high when the selected port's FSM is not in CMD and that port has at least one free tag.
REQ-004 SHALL accept a request on a rising edge with in_valid && in_ready; only the port addressed by in_port changes state.
REQ-005 SHALL register all outputs. Accept at edge k: cycle k+1 drives cmd = in_cmd, data = in_op1, tag = allocated (FSM in CMD). Cycle k+2 drives cmd = 0, data = in_op2, tag = 0 (FSM in DATA).
REQ-006 SHALL drive cmd = 0, data = 0, tag = 0 in IDLE.
REQ-007 SHALL return the FSM from DATA to IDLE, or directly to CMD if a new request is accepted that cycle, giving back-to-back issue every 2 cycles.
REQ-008 SHALL allocate the lowest-numbered free tag of the port and set its tag_busy bit on accept.
REQ-009 SHALL clear tag_busy[N,t] on the edge after a cycle with out_respN != 0 and out_tagN = t.
REQ-010 SHALL evaluate allocation against the pre-edge busy map when a free and an allocate coincide, so a tag freed this cycle is reusable only from the next cycle.
REQ-011 SHALL set proto_err and change no tag state when a nonzero response arrives for a tag not marked busy; proto_err clears only by reset.
REQ-012 SHALL forward any in_cmd value unmodified, including invalid codes (calc2 answers resp 3).
REQ-013 SHALL keep the 4 ports fully independent; concurrent activity on different ports never stalls.

Reset
REQ-014 SHALL, while reset_n is low: set all reqN_* outputs to 0, tag_busy to 0, proto_err to 0, all FSMs to IDLE.
REQ-015 SHALL abandon any request in flight when reset asserts mid-operation (including in CMD or DATA); no partial command reappears after release.
REQ-016 SHALL allow in_ready to assert in the first cycle after reset_n deasserts.

Structure
REQ-017 SHALL take from shared package calc2_pkg: command codes (NOP 0, ADD 1, SUB 2, SHL 5, SHR 6), response codes (NONE 0, OK 1, OVF 2, INV 3), data/tag widths, and the port FSM state enum.
REQ-018 SHALL implement each port in one sub-module, calc2_port_issuer, instantiated 4 times; the top holds only request steering and the in_ready mux.

Verification
REQ-019 Single add: port 0, cmd 1, op1 5, op2 7 -> req1 shows cmd 1/data 5/tag 0, then cmd 0/data 7; tag_busy = 0x0001.
REQ-020 Tag exhaustion: 4 requests to port 1 with no responses -> tags 0,1,2,3 in order; in_ready low for in_port = 1; still high for ports 0, 2, 3.
REQ-021 Tag recycle: after REQ-020, out_resp2 = 1, tag 2 -> next port-1 request gets tag 2 one cycle later; never in the same cycle.
REQ-022 Parallel ports: accept one request per port on consecutive cycles -> each port issues at k+1 and k+2 independently, no stalls.
REQ-023 Spurious response: out_resp3 = 1, tag 3 with nothing outstanding -> proto_err = 1; tag_busy unchanged.
REQ-024 Reset mid-op: assert reset_n low while port 0 is in CMD -> outputs 0, tag_busy 0; no op2 cycle follows release.
